zcull_stage: RTL

//   Depth-test kernel in the rendering pipeline's page chain. Sits directly downstream of
//   the triangle-coloring page's Output_1 stream, delivered via the leaf interface.
//   Per frame: consumes a fragment stream, keeps an on-chip z-buffer, emits surviving pixels.

---
 rtl/zcull_stage_pkg.sv | 21 ++
 rtl/zcull_stage_if.sv | 11 +
 rtl/zcull_stage_zbuf_ram.sv | 23 ++
 rtl/zcull_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/zcull_stage_pkg.sv
// Shared rendering definitions for the z-cull stage: fragment field layout,
// trailer tag and the frame FSM state encoding.
package zcull_stage_pkg;

    localparam int FRAG_X_LSB = 24;
    localparam int FRAG_Y_LSB = 16;
    localparam int FRAG_Z_LSB = 8;
    localparam int FRAG_C_LSB = 0;

    localparam logic [15:0] TRAILER_TAG = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HDR   = 3'd2,
        ST_FRAG  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_TRAIL = 3'd5
    } state_t;

endpackage

// File: rtl/zcull_stage_if.sv
// 32-bit valid/ready stream used for both the fragment input and pixel output.
interface zcull_stage_if;

    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/zcull_stage_zbuf_ram.sv
// Simple dual-port z-buffer RAM: one write port, one registered read port,
// read-first when both ports hit the same address in the same cycle.
module zbuf_ram #(
    parameter int AW = 16,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/zcull_stage.sv
// Depth-test stage: clears the z-buffer, then per frame reads a header, culls
// fragments against the z-buffer, emits survivors and ends with a count trailer.
module zcull_stage
    import zcull_stage_pkg::*;
#(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 8
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          ap_start,
    output logic          ap_done,
    output logic          ap_idle,
    output logic          ap_ready,
    zcull_stage_if.slave  Input_1_V,
    zcull_stage_if.master Output_1_V
);

    localparam int AW = X_BITS + Y_BITS;

    state_t            state;
    logic              epoch;
    logic [AW-1:0]     clear_addr;
    logic [15:0]       frags_left;
    logic [15:0]       pass_cnt;

    logic              p_valid;
    logic [AW-1:0]     p_addr;
    logic [X_BITS-1:0] p_x;
    logic [Y_BITS-1:0] p_y;
    logic [7:0]        p_z;
    logic [7:0]        p_c;

    logic              fwd_valid;
    logic [AW-1:0]     fwd_addr;
    logic              fwd_tag;
    logic [7:0]        fwd_z;

    logic              out_valid;
    logic [31:0]       out_data;

    logic              en;
    logic              in_tready;
    logic              frag_accept;
    logic [X_BITS-1:0] in_x;
    logic [Y_BITS-1:0] in_y;
    logic [8:0]        ram_rdata;
    logic [8:0]        stored;
    logic              pass;
    logic              retire;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [8:0]        ram_wdata;

    assign en          = !out_valid || Output_1_V.tready;
    assign in_tready   = (state == ST_HDR) ||
                         (state == ST_FRAG && en && frags_left != 16'd0);
    assign frag_accept = (state == ST_FRAG) && in_tready && Input_1_V.tvalid;
    assign in_x        = Input_1_V.tdata[FRAG_X_LSB +: X_BITS];
    assign in_y        = Input_1_V.tdata[FRAG_Y_LSB +: Y_BITS];

    // The forward reg stands in for a write the RAM read missed one cycle ago.
    assign stored = (fwd_valid && fwd_addr == p_addr) ? {fwd_tag, fwd_z} : ram_rdata;
    assign pass   = (stored[8] != epoch) || (p_z < stored[7:0]);
    assign retire = en && p_valid;

    assign ram_we    = (state == ST_CLEAR) || (retire && pass);
    assign ram_waddr = (state == ST_CLEAR) ? clear_addr : p_addr;
    assign ram_wdata = (state == ST_CLEAR) ? 9'h100 : {epoch, p_z};

    zbuf_ram #(.AW(AW), .DW(9)) u_zbuf (
        .clk   (ap_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (frag_accept),
        .raddr ({in_y, in_x}),
        .rdata (ram_rdata)
    );

    assign Input_1_V.tready  = in_tready;
    assign Output_1_V.tvalid = out_valid;
    assign Output_1_V.tdata  = out_data;
    assign ap_idle           = (state == ST_IDLE);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= ST_CLEAR;
            epoch      <= 1'b0;
            clear_addr <= '0;
            frags_left <= '0;
            pass_cnt   <= '0;
            p_valid    <= 1'b0;
            p_addr     <= '0;
            p_x        <= '0;
            p_y        <= '0;
            p_z        <= '0;
            p_c        <= '0;
            fwd_valid  <= 1'b0;
            fwd_addr   <= '0;
            fwd_tag    <= 1'b0;
            fwd_z      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            ap_done    <= 1'b0;
            ap_ready   <= 1'b0;
        end else begin
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;

            if (out_valid && Output_1_V.tready) out_valid <= 1'b0;

            if (retire) begin
                if (pass) begin
                    out_valid <= 1'b1;
                    out_data  <= {8'(p_x), 8'(p_y), p_c, 8'h00};
                    pass_cnt  <= pass_cnt + 16'd1;
                    fwd_valid <= 1'b1;
                    fwd_addr  <= p_addr;
                    fwd_tag   <= epoch;
                    fwd_z     <= p_z;
                end else begin
                    fwd_valid <= 1'b0;
                end
            end

            // Stage S1 only advances on enabled cycles so a stall freezes it.
            if (en) p_valid <= frag_accept;
            if (frag_accept) begin
                p_addr <= {in_y, in_x};
                p_x    <= in_x;
                p_y    <= in_y;
                p_z    <= Input_1_V.tdata[FRAG_Z_LSB +: 8];
                p_c    <= Input_1_V.tdata[FRAG_C_LSB +: 8];
            end

            case (state)
                ST_CLEAR: begin
                    clear_addr <= clear_addr + 1'b1;
                    if (&clear_addr) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (ap_start) state <= ST_HDR;
                end
                ST_HDR: begin
                    if (Input_1_V.tvalid) begin
                        frags_left <= Input_1_V.tdata[15:0];
                        pass_cnt   <= '0;
                        state      <= (Input_1_V.tdata[15:0] == 16'd0) ? ST_TRAIL : ST_FRAG;
                    end
                end
                ST_FRAG: begin
                    if (frag_accept) begin
                        frags_left <= frags_left - 16'd1;
                        if (frags_left == 16'd1) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!p_valid && !out_valid) state <= ST_TRAIL;
                end
                ST_TRAIL: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= {TRAILER_TAG, pass_cnt};
                    end else if (Output_1_V.tready) begin
                        ap_done  <= 1'b1;
                        ap_ready <= 1'b1;
                        epoch    <= ~epoch;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule
